// File: rtl/iob_eth_dma_sched_pkg.sv
// Shared definitions for the Ethernet DMA request scheduler.
//   - FSM state encoding (plain localparams so legacy code can compare them)
//   - per-direction status codes
//   - descriptor length width and the byte-to-word conversion helper
package iob_eth_dma_sched_pkg;

  // The length field is 12 bits wide so that 2048 (a full buffer) and
  // 2049 (one byte too many) are both representable.
  localparam int NBYTES_W = 12;
  // Width of the engine length port, in 32-bit words.
  localparam int WORDS_W  = 10;
  // Full-precision word count. The length check uses this width so that
  // oversized frames cannot alias onto small legal values.
  localparam int WCALC_W  = NBYTES_W - 1;

  localparam int DIR_TX = 0;
  localparam int DIR_RX = 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_LOW  = 3'd2;
  localparam logic [2:0] S_WAIT_HIGH = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_BADLEN  = 2'b01,
    ST_ALIGN   = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;

  // ceil(nbytes / 4) without losing the carry out of the +3.
  function automatic logic [WCALC_W-1:0] bytes_to_words(input logic [NBYTES_W-1:0] nbytes);
    logic [NBYTES_W:0] sum;
    sum = {1'b0, nbytes} + (NBYTES_W + 1)'(3);
    return sum[NBYTES_W:2];
  endfunction

endpackage

// File: rtl/iob_eth_dma_sched_if.sv
// Bundle of every non-clock signal of the DMA scheduler.
//   tx_req_* / rx_req_*  : descriptor offer (valid/ready/addr/nbytes)
//   tx_done / rx_done    : one-cycle completion pulse, with tx_status/rx_status
//   timeout_cycles       : watchdog limit, 0 disables
//   busy                 : scheduler not idle
//   dma_*                : configuration port of the DMA engine
// Modports: master = front end + engine side, slave = the scheduler.
interface iob_eth_dma_sched_if
  import iob_eth_dma_sched_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int TIMEOUT_W  = 16
);
  logic                  tx_req_valid;
  logic                  tx_req_ready;
  logic [AXI_ADDR_W-1:0] tx_req_addr;
  logic [NBYTES_W-1:0]   tx_req_nbytes;
  logic                  tx_done;
  logic [1:0]            tx_status;

  logic                  rx_req_valid;
  logic                  rx_req_ready;
  logic [AXI_ADDR_W-1:0] rx_req_addr;
  logic [NBYTES_W-1:0]   rx_req_nbytes;
  logic                  rx_done;
  logic [1:0]            rx_status;

  logic [TIMEOUT_W-1:0]  timeout_cycles;
  logic                  busy;

  logic [AXI_ADDR_W-1:0] dma_addr;
  logic [WORDS_W-1:0]    dma_len;
  logic                  dma_run;
  logic                  dma_read_from_not_write;
  logic                  dma_ready;

  modport master (
    output tx_req_valid, tx_req_addr, tx_req_nbytes,
    output rx_req_valid, rx_req_addr, rx_req_nbytes,
    output timeout_cycles, dma_ready,
    input  tx_req_ready, tx_done, tx_status,
    input  rx_req_ready, rx_done, rx_status,
    input  busy, dma_addr, dma_len, dma_run, dma_read_from_not_write
  );

  modport slave (
    input  tx_req_valid, tx_req_addr, tx_req_nbytes,
    input  rx_req_valid, rx_req_addr, rx_req_nbytes,
    input  timeout_cycles, dma_ready,
    output tx_req_ready, tx_done, tx_status,
    output rx_req_ready, rx_done, rx_status,
    output busy, dma_addr, dma_len, dma_run, dma_read_from_not_write
  );
endinterface

// File: rtl/iob_eth_dma_slot.sv
// One-deep descriptor slot for a single DMA direction.
// Latches address, word count and a validation code when a descriptor is
// accepted (req_valid & req_ready); holds it pending until clear.
//   req_valid/req_ready/req_addr/req_nbytes : descriptor offer
//   clear                                   : release the slot (from scheduler)
//   pending/addr/words/err                  : latched descriptor
module iob_eth_dma_slot
  import iob_eth_dma_sched_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int MAX_WORDS  = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AXI_ADDR_W-1:0] req_addr,
  input  logic [NBYTES_W-1:0]   req_nbytes,
  input  logic                  clear,
  output logic                  pending,
  output logic [AXI_ADDR_W-1:0] addr,
  output logic [WORDS_W-1:0]    words,
  output status_t               err
);
  localparam logic [WCALC_W-1:0] MAX_W = WCALC_W'(MAX_WORDS);

  logic                  pending_reg;
  logic [AXI_ADDR_W-1:0] addr_reg;
  logic [WORDS_W-1:0]    words_reg;
  status_t               err_reg;

  logic [WCALC_W-1:0]    words_full;
  status_t               err_next;

  // Length errors take precedence over alignment errors.
  always_comb begin
    words_full = bytes_to_words(req_nbytes);
    if (req_nbytes == '0 || words_full > MAX_W) begin
      err_next = ST_BADLEN;
    end else if (req_addr[1:0] != 2'b00) begin
      err_next = ST_ALIGN;
    end else begin
      err_next = ST_OK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 1'b0;
      addr_reg    <= '0;
      words_reg   <= '0;
      err_reg     <= ST_OK;
    end else begin
      // clear only happens while pending, so it never races an accept.
      if (clear) begin
        pending_reg <= 1'b0;
      end
      if (req_valid && !pending_reg) begin
        pending_reg <= 1'b1;
        addr_reg    <= req_addr;
        words_reg   <= words_full[WORDS_W-1:0];
        err_reg     <= err_next;
      end
    end
  end

  assign req_ready = ~pending_reg;
  assign pending   = pending_reg;
  assign addr      = addr_reg;
  assign words     = words_reg;
  assign err       = err_reg;
endmodule

// File: rtl/iob_eth_dma_sched.sv
// Ethernet DMA request scheduler.
// Holds one TX and one RX descriptor, arbitrates round-robin between them,
// configures and starts the DMA engine, tracks completion via dma_ready,
// enforces an optional watchdog and reports per-direction done/status.
// Ports: clk, rst (sync, active-high), bus (slave modport: descriptor
// offers, done/status, busy, timeout_cycles and the engine config port).
module iob_eth_dma_sched
  import iob_eth_dma_sched_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int MAX_WORDS  = 512,
  parameter int TIMEOUT_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  iob_eth_dma_sched_if.slave  bus
);
  // Index 0 = TX, index 1 = RX throughout.
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            pending;
  logic [1:0]            clear;
  logic [AXI_ADDR_W-1:0] req_addr   [2];
  logic [NBYTES_W-1:0]   req_nbytes [2];
  logic [AXI_ADDR_W-1:0] slot_addr  [2];
  logic [WORDS_W-1:0]    slot_words [2];
  status_t               slot_err   [2];

  assign req_valid              = {bus.rx_req_valid, bus.tx_req_valid};
  assign req_addr[DIR_TX]       = bus.tx_req_addr;
  assign req_addr[DIR_RX]       = bus.rx_req_addr;
  assign req_nbytes[DIR_TX]     = bus.tx_req_nbytes;
  assign req_nbytes[DIR_RX]     = bus.rx_req_nbytes;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      iob_eth_dma_slot #(
        .AXI_ADDR_W (AXI_ADDR_W),
        .MAX_WORDS  (MAX_WORDS)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[gi]),
        .req_ready  (req_ready[gi]),
        .req_addr   (req_addr[gi]),
        .req_nbytes (req_nbytes[gi]),
        .clear      (clear[gi]),
        .pending    (pending[gi]),
        .addr       (slot_addr[gi]),
        .words      (slot_words[gi]),
        .err        (slot_err[gi])
      );
    end
  endgenerate

  logic [2:0]            state_reg, state_next;
  logic                  gnt_rx_reg;   // direction of the transfer in flight
  logic                  last_rx_reg;  // direction granted most recently
  logic [TIMEOUT_W-1:0]  wdog_reg;
  logic [AXI_ADDR_W-1:0] dma_addr_reg;
  logic [WORDS_W-1:0]    dma_len_reg;
  logic                  dma_dir_reg;
  logic                  dma_run_reg;
  logic [1:0]            done_reg;
  status_t               status_reg [2];

  logic                  grant;
  logic                  grant_rx;
  logic                  timeout_hit;
  logic                  enter_done;
  logic                  done_dir;
  status_t               done_status;

  assign timeout_hit = (bus.timeout_cycles != '0) && (wdog_reg >= bus.timeout_cycles);

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_rx   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (pending != 2'b00) begin
          grant = 1'b1;
          // Only RX pending, or a tie where TX went last (reset state).
          grant_rx   = pending[DIR_RX] && (!pending[DIR_TX] || !last_rx_reg);
          state_next = (slot_err[grant_rx] != ST_OK) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE:     state_next = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!bus.dma_ready)  state_next = S_WAIT_HIGH;
        else if (timeout_hit) state_next = S_DRAIN;
      end
      S_WAIT_HIGH: begin
        // A completion seen in the same cycle as the timeout still wins.
        if (bus.dma_ready)    state_next = S_DONE;
        else if (timeout_hit) state_next = S_DRAIN;
      end
      // The engine cannot be aborted, so a timed-out transfer waits here
      // until the engine is idle before the next one may start.
      S_DRAIN:     if (bus.dma_ready) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Status and direction for the done pulse, decided on the way into DONE.
  always_comb begin
    case (state_reg)
      S_IDLE:  done_status = slot_err[grant_rx];
      S_DRAIN: done_status = ST_TIMEOUT;
      default: done_status = ST_OK;
    endcase
    done_dir   = (state_reg == S_IDLE) ? grant_rx : gnt_rx_reg;
    enter_done = (state_next == S_DONE) && (state_reg != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= S_IDLE;
      gnt_rx_reg         <= 1'b0;
      last_rx_reg        <= 1'b0;
      wdog_reg           <= '0;
      dma_addr_reg       <= '0;
      dma_len_reg        <= '0;
      dma_dir_reg        <= 1'b0;
      dma_run_reg        <= 1'b0;
      done_reg           <= 2'b00;
      status_reg[DIR_TX] <= ST_OK;
      status_reg[DIR_RX] <= ST_OK;
    end else begin
      state_reg   <= state_next;
      dma_run_reg <= 1'b0;
      done_reg    <= 2'b00;
      if (grant) begin
        gnt_rx_reg   <= grant_rx;
        last_rx_reg  <= grant_rx;
        dma_addr_reg <= slot_addr[grant_rx];
        dma_len_reg  <= slot_words[grant_rx];
        dma_dir_reg  <= grant_rx;
        wdog_reg     <= '0;
        // Start pulse lands in the ISSUE cycle; rejected descriptors never run.
        dma_run_reg  <= (slot_err[grant_rx] == ST_OK);
      end
      if ((state_reg == S_WAIT_LOW || state_reg == S_WAIT_HIGH) && wdog_reg != '1) begin
        wdog_reg <= wdog_reg + 1'b1;
      end
      if (enter_done) begin
        done_reg[done_dir]   <= 1'b1;
        status_reg[done_dir] <= done_status;
      end
    end
  end

  assign clear[DIR_TX] = (state_reg == S_DONE) && !gnt_rx_reg;
  assign clear[DIR_RX] = (state_reg == S_DONE) &&  gnt_rx_reg;

  assign bus.tx_req_ready            = req_ready[DIR_TX];
  assign bus.rx_req_ready            = req_ready[DIR_RX];
  assign bus.tx_done                 = done_reg[DIR_TX];
  assign bus.rx_done                 = done_reg[DIR_RX];
  assign bus.tx_status               = status_reg[DIR_TX];
  assign bus.rx_status               = status_reg[DIR_RX];
  assign bus.busy                    = (state_reg != S_IDLE);
  assign bus.dma_addr                = dma_addr_reg;
  assign bus.dma_len                 = dma_len_reg;
  assign bus.dma_run                 = dma_run_reg;
  assign bus.dma_read_from_not_write = dma_dir_reg;
endmodule

// File: tb/tb_iob_eth_dma_sched.sv
// Directed testbench for iob_eth_dma_sched. The DMA engine is played by the
// bench: it drops dma_ready after the start pulse and raises it again after
// a chosen number of cycles.
module tb_iob_eth_dma_sched;
  import iob_eth_dma_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   run_cnt = 0;
  int   tx_done_cnt = 0;
  int   rx_done_cnt = 0;

  always #5 clk = ~clk;

  iob_eth_dma_sched_if #(.AXI_ADDR_W(32), .TIMEOUT_W(16)) bus();

  iob_eth_dma_sched #(
    .AXI_ADDR_W (32),
    .MAX_WORDS  (512),
    .TIMEOUT_W  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Event counters (values of the cycle that just ended).
  always @(posedge clk) begin
    if (bus.dma_run === 1'b1) run_cnt++;
    if (bus.tx_done === 1'b1) tx_done_cnt++;
    if (bus.rx_done === 1'b1) rx_done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents descriptors for one cycle; returns in the cycle after accept.
  task automatic offer(input bit do_tx, input logic [31:0] ta, input logic [11:0] tn,
                       input bit do_rx, input logic [31:0] ra, input logic [11:0] rn);
    bus.tx_req_valid  = do_tx;
    bus.tx_req_addr   = ta;
    bus.tx_req_nbytes = tn;
    bus.rx_req_valid  = do_rx;
    bus.rx_req_addr   = ra;
    bus.rx_req_nbytes = rn;
    if (do_tx) $display("offer tx addr=%h nbytes=%0d", ta, tn);
    if (do_rx) $display("offer rx addr=%h nbytes=%0d", ra, rn);
    step(1);
    bus.tx_req_valid = 1'b0;
    bus.rx_req_valid = 1'b0;
  endtask

  // Called in the ISSUE cycle; returns in the DONE cycle.
  task automatic engine(input int low);
    step(1);
    bus.dma_ready = 1'b0;
    step(low);
    bus.dma_ready = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    checks++; if (bus.tx_req_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", bus.tx_req_ready); end
    checks++; if (bus.rx_req_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready: got %b want 1", bus.rx_req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if ({bus.tx_done, bus.rx_done, bus.tx_status, bus.rx_status} !== 6'b0) begin errors++; $display("FAIL rst_done_status: got %b want 0", {bus.tx_done, bus.rx_done, bus.tx_status, bus.rx_status}); end
    checks++; if ({bus.dma_run, bus.dma_read_from_not_write, bus.dma_len, bus.dma_addr} !== 44'b0) begin errors++; $display("FAIL rst_dma: got run=%b dir=%b len=%0d addr=%h want all 0", bus.dma_run, bus.dma_read_from_not_write, bus.dma_len, bus.dma_addr); end
    $display("reset checked");
  endtask

  task automatic test_tx_only();
    int r0;
    r0 = run_cnt;
    offer(1'b1, 32'h1000, 12'd60, 1'b0, 32'h0, 12'd0);
    checks++; if (bus.tx_req_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_after_accept: got %b want 0", bus.tx_req_ready); end
    checks++; if (bus.dma_run !== 1'b0) begin errors++; $display("FAIL tx_run_early: got %b want 0", bus.dma_run); end
    step(1);
    checks++; if (bus.dma_run !== 1'b1) begin errors++; $display("FAIL tx_run: got %b want 1", bus.dma_run); end
    checks++; if (bus.dma_len !== 10'd15) begin errors++; $display("FAIL tx_len: got %0d want 15", bus.dma_len); end
    checks++; if (bus.dma_read_from_not_write !== 1'b0) begin errors++; $display("FAIL tx_dir: got %b want 0", bus.dma_read_from_not_write); end
    checks++; if (bus.dma_addr !== 32'h1000) begin errors++; $display("FAIL tx_addr: got %h want 1000", bus.dma_addr); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL tx_busy: got %b want 1", bus.busy); end
    engine(20);
    checks++; if (bus.tx_done !== 1'b1) begin errors++; $display("FAIL tx_done: got %b want 1", bus.tx_done); end
    checks++; if (bus.tx_status !== 2'b00) begin errors++; $display("FAIL tx_status: got %b want 00", bus.tx_status); end
    checks++; if (bus.rx_done !== 1'b0) begin errors++; $display("FAIL tx_rx_done: got %b want 0", bus.rx_done); end
    step(1);
    checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL tx_done_pulse: got %b want 0", bus.tx_done); end
    checks++; if (bus.tx_req_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_after_done: got %b want 1", bus.tx_req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tx_idle: got %b want 0", bus.busy); end
    checks++; if (run_cnt !== r0 + 1) begin errors++; $display("FAIL tx_run_count: got %0d want %0d", run_cnt - r0, 1); end
    $display("tx transfer complete status=%b", bus.tx_status);
  endtask

  task automatic test_round_robin();
    offer(1'b1, 32'h2000, 12'd40, 1'b1, 32'h3000, 12'd80);
    step(1);
    checks++; if (bus.dma_run !== 1'b1 || bus.dma_read_from_not_write !== 1'b1) begin errors++; $display("FAIL rr_first_rx: got run=%b dir=%b want 1 1", bus.dma_run, bus.dma_read_from_not_write); end
    checks++; if (bus.dma_addr !== 32'h3000 || bus.dma_len !== 10'd20) begin errors++; $display("FAIL rr_rx_cfg: got addr=%h len=%0d want 3000 20", bus.dma_addr, bus.dma_len); end
    engine(3);
    checks++; if (bus.rx_done !== 1'b1 || bus.rx_status !== 2'b00) begin errors++; $display("FAIL rr_rx_done: got done=%b st=%b want 1 00", bus.rx_done, bus.rx_status); end
    checks++; if (bus.tx_req_ready !== 1'b0) begin errors++; $display("FAIL rr_tx_still_pending: got %b want 0", bus.tx_req_ready); end
    $display("rr rx transfer complete");
    step(2);
    checks++; if (bus.dma_run !== 1'b1 || bus.dma_read_from_not_write !== 1'b0 || bus.dma_addr !== 32'h2000) begin errors++; $display("FAIL rr_then_tx: got run=%b dir=%b addr=%h want 1 0 2000", bus.dma_run, bus.dma_read_from_not_write, bus.dma_addr); end
    engine(3);
    checks++; if (bus.tx_done !== 1'b1) begin errors++; $display("FAIL rr_tx_done: got %b want 1", bus.tx_done); end
    $display("rr tx transfer complete");
    step(1);
    // RX alone, so RX becomes the last grant.
    offer(1'b0, 32'h0, 12'd0, 1'b1, 32'h3100, 12'd16);
    step(1);
    checks++; if (bus.dma_run !== 1'b1 || bus.dma_read_from_not_write !== 1'b1) begin errors++; $display("FAIL rr_rx_alone: got run=%b dir=%b want 1 1", bus.dma_run, bus.dma_read_from_not_write); end
    engine(2);
    step(1);
    // Second tie must go to TX.
    offer(1'b1, 32'h2200, 12'd8, 1'b1, 32'h3200, 12'd12);
    step(1);
    checks++; if (bus.dma_run !== 1'b1 || bus.dma_read_from_not_write !== 1'b0 || bus.dma_addr !== 32'h2200) begin errors++; $display("FAIL rr_second_tie_tx: got run=%b dir=%b addr=%h want 1 0 2200", bus.dma_run, bus.dma_read_from_not_write, bus.dma_addr); end
    engine(2);
    checks++; if (bus.tx_done !== 1'b1) begin errors++; $display("FAIL rr_tie_tx_done: got %b want 1", bus.tx_done); end
    step(2);
    checks++; if (bus.dma_run !== 1'b1 || bus.dma_read_from_not_write !== 1'b1 || bus.dma_len !== 10'd3) begin errors++; $display("FAIL rr_tie_rx_next: got run=%b dir=%b len=%0d want 1 1 3", bus.dma_run, bus.dma_read_from_not_write, bus.dma_len); end
    engine(2);
    checks++; if (bus.rx_done !== 1'b1) begin errors++; $display("FAIL rr_tie_rx_done: got %b want 1", bus.rx_done); end
    step(1);
    $display("round robin sequence complete");
  endtask

  logic [11:0] inv_nb   [4] = '{12'd2049, 12'd0, 12'd64, 12'd0};
  logic [31:0] inv_addr [4] = '{32'h2000, 32'h2000, 32'h1002, 32'h2003};
  logic        inv_dir  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0]  inv_exp  [4] = '{2'b01, 2'b01, 2'b10, 2'b01};

  task automatic test_invalid();
    int r0;
    logic d;
    for (int i = 0; i < 4; i++) begin
      r0 = run_cnt;
      if (inv_dir[i]) offer(1'b0, 32'h0, 12'd0, 1'b1, inv_addr[i], inv_nb[i]);
      else            offer(1'b1, inv_addr[i], inv_nb[i], 1'b0, 32'h0, 12'd0);
      d = inv_dir[i] ? bus.rx_done : bus.tx_done;
      checks++; if (d !== 1'b0) begin errors++; $display("FAIL inv%0d_done_early: got %b want 0", i, d); end
      step(1);
      d = inv_dir[i] ? bus.rx_done : bus.tx_done;
      checks++; if (d !== 1'b1) begin errors++; $display("FAIL inv%0d_done: got %b want 1", i, d); end
      checks++; if ((inv_dir[i] ? bus.rx_status : bus.tx_status) !== inv_exp[i]) begin errors++; $display("FAIL inv%0d_status: got %b want %b", i, inv_dir[i] ? bus.rx_status : bus.tx_status, inv_exp[i]); end
      checks++; if (bus.dma_run !== 1'b0) begin errors++; $display("FAIL inv%0d_run: got %b want 0", i, bus.dma_run); end
      step(1);
      checks++; if ((inv_dir[i] ? bus.rx_req_ready : bus.tx_req_ready) !== 1'b1) begin errors++; $display("FAIL inv%0d_ready: got 0 want 1", i); end
      checks++; if (run_cnt !== r0) begin errors++; $display("FAIL inv%0d_no_run: got %0d runs want 0", i, run_cnt - r0); end
      $display("invalid descriptor %0d reported status=%b", i, inv_exp[i]);
    end
  endtask

  task automatic test_boundary();
    offer(1'b1, 32'h4000, 12'd2048, 1'b0, 32'h0, 12'd0);
    step(1);
    checks++; if (bus.dma_run !== 1'b1 || bus.dma_len !== 10'd512) begin errors++; $display("FAIL bnd_2048: got run=%b len=%0d want 1 512", bus.dma_run, bus.dma_len); end
    engine(2);
    checks++; if (bus.tx_done !== 1'b1 || bus.tx_status !== 2'b00) begin errors++; $display("FAIL bnd_2048_done: got done=%b st=%b want 1 00", bus.tx_done, bus.tx_status); end
    step(1);
    offer(1'b0, 32'h0, 12'd0, 1'b1, 32'h5004, 12'd61);
    step(1);
    checks++; if (bus.dma_run !== 1'b1 || bus.dma_len !== 10'd16 || bus.dma_read_from_not_write !== 1'b1) begin errors++; $display("FAIL bnd_61: got run=%b len=%0d dir=%b want 1 16 1", bus.dma_run, bus.dma_len, bus.dma_read_from_not_write); end
    engine(2);
    checks++; if (bus.rx_done !== 1'b1 || bus.rx_status !== 2'b00) begin errors++; $display("FAIL bnd_61_done: got done=%b st=%b want 1 00", bus.rx_done, bus.rx_status); end
    step(1);
    $display("boundary lengths complete");
  endtask

  task automatic test_timeout();
    int r0;
    r0 = run_cnt;
    bus.timeout_cycles = 16'd8;
    offer(1'b1, 32'h6000, 12'd40, 1'b0, 32'h0, 12'd0);
    step(1);
    checks++; if (bus.dma_run !== 1'b1) begin errors++; $display("FAIL to_run: got %b want 1", bus.dma_run); end
    offer(1'b0, 32'h0, 12'd0, 1'b1, 32'h7000, 12'd20);
    bus.dma_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      checks++; if ({bus.tx_done, bus.rx_done, bus.dma_run} !== 3'b000) begin errors++; $display("FAIL to_hold%0d: got done_tx=%b done_rx=%b run=%b want 000", i, bus.tx_done, bus.rx_done, bus.dma_run); end
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL to_busy: got %b want 1", bus.busy); end
    bus.dma_ready = 1'b1;
    step(1);
    checks++; if (bus.tx_done !== 1'b1 || bus.tx_status !== 2'b11) begin errors++; $display("FAIL to_status: got done=%b st=%b want 1 11", bus.tx_done, bus.tx_status); end
    checks++; if (run_cnt !== r0 + 1) begin errors++; $display("FAIL to_rx_not_run: got %0d runs want 1", run_cnt - r0); end
    $display("tx timeout reported status=%b", bus.tx_status);
    step(2);
    checks++; if (bus.dma_run !== 1'b1 || bus.dma_read_from_not_write !== 1'b1) begin errors++; $display("FAIL to_rx_run: got run=%b dir=%b want 1 1", bus.dma_run, bus.dma_read_from_not_write); end
    engine(3);
    checks++; if (bus.rx_done !== 1'b1 || bus.rx_status !== 2'b00) begin errors++; $display("FAIL to_rx_done: got done=%b st=%b want 1 00", bus.rx_done, bus.rx_status); end
    step(1);
    bus.timeout_cycles = 16'd0;
    $display("rx after timeout complete");
  endtask

  task automatic test_reset_mid();
    int t0, x0, r1;
    offer(1'b1, 32'h8000, 12'd32, 1'b0, 32'h0, 12'd0);
    offer(1'b0, 32'h0, 12'd0, 1'b1, 32'h9000, 12'd32);
    bus.dma_ready = 1'b0;
    step(2);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b want 1", bus.busy); end
    t0 = tx_done_cnt;
    x0 = rx_done_cnt;
    rst = 1'b1;
    step(1);
    r1 = run_cnt;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
    checks++; if (bus.tx_req_ready !== 1'b1 || bus.rx_req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got tx=%b rx=%b want 1 1", bus.tx_req_ready, bus.rx_req_ready); end
    checks++; if ({bus.dma_run, bus.dma_read_from_not_write, bus.dma_len, bus.dma_addr} !== 44'b0) begin errors++; $display("FAIL rm_dma: got run=%b dir=%b len=%0d addr=%h want all 0", bus.dma_run, bus.dma_read_from_not_write, bus.dma_len, bus.dma_addr); end
    rst = 1'b0;
    bus.dma_ready = 1'b1;
    step(6);
    checks++; if (tx_done_cnt !== t0 || rx_done_cnt !== x0) begin errors++; $display("FAIL rm_no_done: got tx=%0d rx=%0d extra pulses want 0", tx_done_cnt - t0, rx_done_cnt - x0); end
    checks++; if (run_cnt !== r1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rm_no_run: got runs=%0d busy=%b want 0 0", run_cnt - r1, bus.busy); end
    $display("reset mid-transfer checked");
  endtask

  initial begin
    bus.tx_req_valid   = 1'b0;
    bus.tx_req_addr    = '0;
    bus.tx_req_nbytes  = '0;
    bus.rx_req_valid   = 1'b0;
    bus.rx_req_addr    = '0;
    bus.rx_req_nbytes  = '0;
    bus.timeout_cycles = '0;
    bus.dma_ready      = 1'b1;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    test_reset();
    test_tx_only();
    test_round_robin();
    test_invalid();
    test_boundary();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
